// File: rtl/en_seq_pkg.sv
// rtl/en_seq_pkg.sv - shared state encoding and default widths for the enable sequencer
package en_seq_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int BURST_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

endpackage

// File: rtl/en_seq_cnt.sv
// rtl/en_seq_cnt.sv - loadable phase down-counter with zero flag, shared by ON and OFF
module en_seq_cnt #(
    parameter int W = 32
) (
    input  logic         clk100m,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] count;

    // Saturates at zero so a stray dec can never wrap into a huge phase.
    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/en_sequencer.sv
// rtl/en_sequencer.sv - burst clock-enable sequencer (IDLE/ON/OFF); optional scope marker via EN_SEQUENCER_MARKER_EN
module en_sequencer
    import en_seq_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk100m,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   cfg_on,
    input  logic [CNT_W-1:0]   cfg_off,
    input  logic [BURST_W-1:0] cfg_bursts,
`ifdef EN_SEQUENCER_MARKER_EN
    output logic               marker,
`endif
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] burst_cnt
);

    localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
    localparam logic [BURST_W:0]   BURST_ONE = 1;

    state_t             state, state_d;
    logic [CNT_W-1:0]   on_q, off_q;
    logic [BURST_W-1:0] bursts_q;

    logic               accept, empty_cfg, more;
    logic [BURST_W:0]   burst_nxt;

    logic               cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]   cnt_val;
    logic               done_d, burst_inc;

    assign accept    = (state == IDLE) && start && !abort;
    assign empty_cfg = (cfg_on == '0) || (cfg_bursts == '0);
    assign burst_nxt = {1'b0, burst_cnt} + BURST_ONE;
    assign more      = burst_nxt < {1'b0, bursts_q};

    // The counter holds "remaining cycles minus one", so zero marks the last cycle of a phase.
    en_seq_cnt #(.W(CNT_W)) u_cnt (
        .clk100m  (clk100m),
        .rstn     (rstn),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            en        <= 1'b0;
            done      <= 1'b0;
            burst_cnt <= '0;
            on_q      <= '0;
            off_q     <= '0;
            bursts_q  <= '0;
        end else begin
            state <= state_d;
            en    <= (state_d == ON);
            done  <= done_d;
            if (accept && !empty_cfg) begin
                on_q     <= cfg_on;
                off_q    <= cfg_off;
                bursts_q <= cfg_bursts;
            end
            if (accept) begin
                burst_cnt <= '0;
            end else if (burst_inc) begin
                burst_cnt <= burst_nxt[BURST_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept && !empty_cfg) state_d = ON;
            ON: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    if (more) state_d = (off_q != '0) ? OFF : ON;
                    else      state_d = IDLE;
                end
            end
            OFF: begin
                if (abort)         state_d = IDLE;
                else if (cnt_zero) state_d = ON;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_val   = '0;
        done_d    = 1'b0;
        burst_inc = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    done_d   = empty_cfg;
                    cnt_load = !empty_cfg;
                    cnt_val  = cfg_on - CNT_ONE;
                end
            end
            ON: begin
                if (abort) begin
                    done_d = 1'b1;
                end else if (cnt_zero) begin
                    burst_inc = 1'b1;
                    if (more) begin
                        cnt_load = 1'b1;
                        cnt_val  = (off_q != '0) ? (off_q - CNT_ONE) : (on_q - CNT_ONE);
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            OFF: begin
                if (abort) begin
                    done_d = 1'b1;
                end else if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = on_q - CNT_ONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

`ifdef EN_SEQUENCER_MARKER_EN
    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) marker <= 1'b0;
        else       marker <= (state_d == ON) && !en;
    end
`endif

endmodule

// File: tb/tb_en_sequencer.sv
// tb/tb_en_sequencer.sv - directed-vector bench for en_sequencer
module tb_en_sequencer;

    logic        clk100m = 1'b0;
    logic        rstn    = 1'b0;
    logic        start   = 1'b0;
    logic        abort   = 1'b0;
    logic [31:0] cfg_on  = '0;
    logic [31:0] cfg_off = '0;
    logic [15:0] cfg_bursts = '0;
    logic        en, busy, done;
    logic [15:0] burst_cnt;
`ifdef EN_SEQUENCER_MARKER_EN
    logic        marker;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk100m = ~clk100m;

    en_sequencer dut (
        .clk100m    (clk100m),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .cfg_on     (cfg_on),
        .cfg_off    (cfg_off),
        .cfg_bursts (cfg_bursts),
`ifdef EN_SEQUENCER_MARKER_EN
        .marker     (marker),
`endif
        .en         (en),
        .busy       (busy),
        .done       (done),
        .burst_cnt  (burst_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Returns at the negedge of the first cycle after the start cycle; cfg is scrambled afterwards.
    task automatic do_start(input logic [31:0] on, input logic [31:0] off, input logic [15:0] b);
        @(negedge clk100m);
        cfg_on = on; cfg_off = off; cfg_bursts = b; start = 1'b1;
        @(negedge clk100m);
        start = 1'b0;
        cfg_on = $urandom_range(50, 1); cfg_off = $urandom_range(50, 1);
        cfg_bursts = 16'($urandom_range(9, 1));
    endtask

    logic [7:0] pat30 = 8'b1110_0111;
    logic [7:0] mrk30 = 8'b1000_0100;

    initial begin
        #12;
        check("rst_en",   {31'd0, en}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_bcnt", {16'd0, burst_cnt}, 0);
        @(negedge clk100m);
        rstn = 1'b1;

        // on=3 off=2 bursts=2
        do_start(3, 2, 2);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("s30_en%0d", i), {31'd0, en}, {31'd0, pat30[7-i]});
            check($sformatf("s30_busy%0d", i), {31'd0, busy}, 1);
            check($sformatf("s30_done%0d", i), {31'd0, done}, 0);
`ifdef EN_SEQUENCER_MARKER_EN
            check($sformatf("s30_mrk%0d", i), {31'd0, marker}, {31'd0, mrk30[7-i]});
`endif
            @(negedge clk100m);
        end
        check("s30_end_en",   {31'd0, en}, 0);
        check("s30_end_done", {31'd0, done}, 1);
        check("s30_end_busy", {31'd0, busy}, 0);
        check("s30_end_bcnt", {16'd0, burst_cnt}, 2);
        @(negedge clk100m);
        check("s30_done_one", {31'd0, done}, 0);

        // on=4 off=0 bursts=3, with an ignored start mid-run
        do_start(4, 0, 3);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("s31_en%0d", i), {31'd0, en}, 1);
            start = (i == 5);
            @(negedge clk100m);
        end
        start = 1'b0;
        check("s31_end_en",   {31'd0, en}, 0);
        check("s31_end_done", {31'd0, done}, 1);
        check("s31_end_bcnt", {16'd0, burst_cnt}, 3);
        @(negedge clk100m);

        // bursts=0, then on=0
        do_start(5, 1, 0);
        check("s33a_en",   {31'd0, en}, 0);
        check("s33a_busy", {31'd0, busy}, 0);
        check("s33a_done", {31'd0, done}, 1);
        check("s33a_bcnt", {16'd0, burst_cnt}, 0);
        @(negedge clk100m);
        check("s33a_done_one", {31'd0, done}, 0);
        do_start(0, 1, 4);
        check("s33b_en",   {31'd0, en}, 0);
        check("s33b_busy", {31'd0, busy}, 0);
        check("s33b_done", {31'd0, done}, 1);
        @(negedge clk100m);

        // on=10 bursts=1, abort on the 5th en-high cycle
        do_start(10, 0, 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("s32_en%0d", i), {31'd0, en}, 1);
            if (i == 4) abort = 1'b1;
            @(negedge clk100m);
        end
        abort = 1'b0;
        check("s32_en",   {31'd0, en}, 0);
        check("s32_done", {31'd0, done}, 1);
        check("s32_bcnt", {16'd0, burst_cnt}, 0);
        @(negedge clk100m);
        check("s32_done_one", {31'd0, done}, 0);

        // start and abort together in IDLE
        cfg_on = 3; cfg_off = 0; cfg_bursts = 1; start = 1'b1; abort = 1'b1;
        @(negedge clk100m);
        start = 1'b0; abort = 1'b0;
        check("s23_en",   {31'd0, en}, 0);
        check("s23_busy", {31'd0, busy}, 0);
        check("s23_done", {31'd0, done}, 0);

        // reset during OFF of a 5-burst run, then a fresh one-cycle run
        do_start(2, 3, 5);
        check("s34_on0", {31'd0, en}, 1);
        @(negedge clk100m);
        check("s34_on1", {31'd0, en}, 1);
        @(negedge clk100m);
        check("s34_off_en",   {31'd0, en}, 0);
        check("s34_off_busy", {31'd0, busy}, 1);
        check("s34_off_bcnt", {16'd0, burst_cnt}, 1);
        #2 rstn = 1'b0;
        #1;
        check("s34_rst_en",   {31'd0, en}, 0);
        check("s34_rst_busy", {31'd0, busy}, 0);
        check("s34_rst_bcnt", {16'd0, burst_cnt}, 0);
        @(negedge clk100m);
        check("s34_rst_done", {31'd0, done}, 0);
        rstn = 1'b1;
        do_start(1, 0, 1);
        check("s34_re_en",   {31'd0, en}, 1);
        check("s34_re_busy", {31'd0, busy}, 1);
        @(negedge clk100m);
        check("s34_re_end_en",   {31'd0, en}, 0);
        check("s34_re_end_done", {31'd0, done}, 1);
        check("s34_re_end_bcnt", {16'd0, burst_cnt}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/en_sequencer.md
EN_SEQUENCER -- requirements
Module: en_sequencer

Interface
REQ-001 SHALL: parameter CNT_W, default 32, width of ON/OFF phase-length fields.
REQ-002 SHALL: parameter BURST_W, default 16, width of burst-count field and burst counter.
REQ-003 SHALL: clk100m  input  1  sole clock; all state rising-edge clocked.
REQ-004 SHALL: rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL: start  input  1  command strobe; accepted only in IDLE.
REQ-006 SHALL: abort  input  1  terminates an active sequence.
REQ-007 SHALL: cfg_on  input  CNT_W  en-high cycles per burst.
REQ-008 SHALL: cfg_off  input  CNT_W  en-low cycles between bursts.
REQ-009 SHALL: cfg_bursts  input  BURST_W  number of ON phases.
REQ-010 SHALL: en  output  1  registered clock-enable for the gated-clock buffer of the load modules.
REQ-011 SHALL: busy  output  1  high while in ON or OFF.
REQ-012 SHALL: done  output  1  one-cycle completion/abort pulse.
REQ-013 SHALL: burst_cnt  output  BURST_W  completed ON phases of the current or last sequence.

Function
REQ-014 SHALL: states IDLE, ON, OFF; en = 1 exactly when state is ON; en driven directly from a flop, never combinational.
REQ-015 SHALL: in IDLE, start=1 and abort=0 latch cfg_on/cfg_off/cfg_bursts, clear burst_cnt, and enter ON on the next edge (en high the cycle after the start cycle).
REQ-016 SHALL: cfg inputs are ignored outside the start-acceptance cycle; start in ON/OFF is ignored.
REQ-017 SHALL: ON lasts exactly cfg_on cycles; on exit burst_cnt increments by 1.
REQ-018 SHALL: if burst_cnt after increment < cfg_bursts, go to OFF when cfg_off > 0, else re-enter ON directly (en stays high continuously).
REQ-019 SHALL: OFF lasts exactly cfg_off cycles, then ON.
REQ-020 SHALL: after the final ON phase go to IDLE with no trailing OFF; done=1 in the first cycle en is low.
REQ-021 SHALL: start with cfg_on=0 or cfg_bursts=0 never asserts en; stays IDLE, pulses done the cycle after start, burst_cnt=0.
REQ-022 SHALL: abort in ON or OFF forces IDLE on the next edge, en low and done=1 that cycle; burst_cnt holds, partial ON not counted.
REQ-023 SHALL: abort and start together in IDLE: no action, no done.
REQ-024 SHALL: phase counters are down-counters loaded with cfg value; no wrap; cfg_on/cfg_off of all-ones is a legal 2^CNT_W-1 cycle phase.

Reset
REQ-025 SHALL: rstn low asynchronously forces IDLE, en=0, busy=0, done=0, burst_cnt=0, counters=0; mid-sequence reset drops en immediately with no done pulse.
REQ-026 SHALL: first start is accepted no earlier than the first edge after rstn deassertion.

Configuration
REQ-027 SHALL: macro EN_SEQUENCER_MARKER_EN, when defined, adds output marker (1 bit) pulsing high for one cycle coincident with every 0->1 transition of en (scope trigger); undefined, port and logic are absent and all other behaviour identical.

Structure
REQ-028 SHALL: shared package en_seq_pkg holds the state enum (IDLE, ON, OFF) and default CNT_W/BURST_W constants.
REQ-029 SHALL: phase timing is a sub-module en_seq_cnt (loadable CNT_W down-counter with load, dec, zero flag), one instance shared by ON and OFF.

Verification
REQ-030 SHALL: start, cfg_on=3, cfg_off=2, cfg_bursts=2 -> en pattern 1,1,1,0,0,1,1,1 starting cycle after start, done in next cycle, burst_cnt=2.
REQ-031 SHALL: cfg_on=4, cfg_off=0, cfg_bursts=3 -> en high 12 consecutive cycles, then done, burst_cnt=3.
REQ-032 SHALL: cfg_on=10, cfg_bursts=1, abort on 5th en-high cycle -> en low next cycle with done=1, burst_cnt=0.
REQ-033 SHALL: cfg_bursts=0 (and separately cfg_on=0) -> en never high, done one cycle after start, busy never high.
REQ-034 SHALL: rstn pulled low during OFF of a 5-burst run -> en, busy, burst_cnt 0 asynchronously, no done; subsequent start runs normally.
REQ-035 SHALL: with EN_SEQUENCER_MARKER_EN defined, run of REQ-030 -> exactly 2 marker pulses aligned with en rising.
